turn_manager: RTL and testbench

TURN_MANAGER -- requirements
Module: turn_manager

---
 rtl/turn_manager_if.sv | 49 ++++
 rtl/turn_manager.sv | 175 +++++++++++++++++
 tb/tb_turn_manager.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/turn_manager_if.sv
// ---------------------------------------------------------------------------
// turn_manager_if
// Signal bundle between the turn manager and the rest of the game.
//   throw_btn   local throw button level (synchronised, debounced)
//   end_throw   one-cycle flight-finished pulse from the simulation stage
//   hp_player1  player 1 health, 7-bit unsigned
//   hp_player2  player 2 health, 7-bit unsigned
//   turn        0 = player 1 throws rightward, 1 = player 2 throws leftward
//   throw_flag  one-cycle throw-start pulse to the simulation stage
//   speed       horizontal step per simulation tick
//   game_over   high once a player is dead
//   winner      00 none, 01 player 1, 10 player 2
// Modports: master = turn manager side, slave = game/simulation side.
// ---------------------------------------------------------------------------
interface turn_manager_if;
  logic       throw_btn;
  logic       end_throw;
  logic [6:0] hp_player1;
  logic [6:0] hp_player2;
  logic       turn;
  logic       throw_flag;
  logic [4:0] speed;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    input  throw_btn,
    input  end_throw,
    input  hp_player1,
    input  hp_player2,
    output turn,
    output throw_flag,
    output speed,
    output game_over,
    output winner
  );

  modport slave (
    output throw_btn,
    output end_throw,
    output hp_player1,
    output hp_player2,
    input  turn,
    input  throw_flag,
    input  speed,
    input  game_over,
    input  winner
  );
endinterface

// File: rtl/turn_manager.sv
// ---------------------------------------------------------------------------
// turn_manager
// Sequences a two-player artillery turn: waits for a fresh button press,
// charges throw speed while the button is held, launches on release, waits
// for the flight to finish (or time out), then either hands the turn to the
// other player or declares a winner.
// Ports:
//   clk60MHz  system clock, rising edge
//   rst       synchronous, active-high reset
//   bus       turn_manager_if.master (button, flight end, health inputs;
//             turn, throw_flag, speed, game_over, winner outputs)
// All outputs are registered; each output register is loaded with the value
// belonging to the state being entered, so outputs change together with the
// state.
// ---------------------------------------------------------------------------
module turn_manager #(
  parameter int unsigned CHARGE_TICK    = 3_000_000,
  parameter int unsigned SPEED_MIN      = 2,
  parameter int unsigned SPEED_MAX      = 20,
  parameter int unsigned FLIGHT_TIMEOUT = 120_000_000
) (
  input  logic           clk60MHz,
  input  logic           rst,
  turn_manager_if.master bus
);

  localparam int unsigned CW = (CHARGE_TICK > 1) ? $clog2(CHARGE_TICK) : 1;

  localparam logic [CW-1:0] CHARGE_LAST = CW'(CHARGE_TICK - 1);
  localparam logic [CW-1:0] CHARGE_ONE  = CW'(1);
  localparam logic [26:0]   FLIGHT_LAST = 27'(FLIGHT_TIMEOUT - 1);
  localparam logic [26:0]   FLIGHT_ONE  = 27'd1;
  localparam logic [4:0]    SPD_MIN     = 5'(SPEED_MIN);
  localparam logic [4:0]    SPD_MAX     = 5'(SPEED_MAX);
  localparam logic [4:0]    SPD_ONE     = 5'd1;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    AIM,
    FLIGHT,
    CHECK,
    SWITCH,
    OVER
  } state_t;

  state_t        state_q, state_d;
  logic          turn_q, turn_d;
  logic          flag_q, flag_d;
  logic [4:0]    speed_q, speed_d;
  logic          go_q, go_d;
  logic [1:0]    win_q, win_d;
  logic [CW-1:0] charge_q, charge_d;
  logic [26:0]   flight_q, flight_d;

  // Health is 7-bit and wraps on underflow, so anything above 100 is a
  // negative result and counts as dead.
  function automatic logic is_dead(input logic [6:0] hp);
    return (hp == 7'd0) || (hp > 7'd100);
  endfunction

  always_comb begin
    state_d  = state_q;
    turn_d   = turn_q;
    flag_d   = 1'b0;
    speed_d  = speed_q;
    go_d     = go_q;
    win_d    = win_q;
    charge_d = charge_q;
    flight_d = flight_q;

    case (state_q)
      // A button still held from the previous throw (or across reset) must
      // be released before a new press can arm a throw.
      IDLE: begin
        if (!bus.throw_btn) begin
          state_d = ARMED;
        end
      end

      ARMED: begin
        if (bus.throw_btn) begin
          state_d  = AIM;
          speed_d  = SPD_MIN;
          charge_d = '0;
        end
      end

      AIM: begin
        if (bus.throw_btn) begin
          if (charge_q == CHARGE_LAST) begin
            charge_d = '0;
            if (speed_q < SPD_MAX) begin
              speed_d = speed_q + SPD_ONE;
            end
          end else begin
            charge_d = charge_q + CHARGE_ONE;
          end
        end else begin
          state_d  = FLIGHT;
          flag_d   = 1'b1;
          flight_d = '0;
        end
      end

      // The flight counter holds the number of completed FLIGHT cycles
      // minus one, so the timeout fires after exactly FLIGHT_TIMEOUT cycles.
      FLIGHT: begin
        if (bus.end_throw || (flight_q == FLIGHT_LAST)) begin
          state_d = CHECK;
        end else begin
          flight_d = flight_q + FLIGHT_ONE;
        end
      end

      // turn is loaded on entry to SWITCH so it is already toggled during
      // the SWITCH cycle.
      CHECK: begin
        if (is_dead(bus.hp_player1)) begin
          state_d = OVER;
          go_d    = 1'b1;
          win_d   = 2'b10;
        end else if (is_dead(bus.hp_player2)) begin
          state_d = OVER;
          go_d    = 1'b1;
          win_d   = 2'b01;
        end else begin
          state_d = SWITCH;
          turn_d  = ~turn_q;
        end
      end

      SWITCH: begin
        state_d = IDLE;
      end

      OVER: begin
        state_d = OVER;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q  <= IDLE;
      turn_q   <= 1'b0;
      flag_q   <= 1'b0;
      speed_q  <= SPD_MIN;
      go_q     <= 1'b0;
      win_q    <= 2'b00;
      charge_q <= '0;
      flight_q <= '0;
    end else begin
      state_q  <= state_d;
      turn_q   <= turn_d;
      flag_q   <= flag_d;
      speed_q  <= speed_d;
      go_q     <= go_d;
      win_q    <= win_d;
      charge_q <= charge_d;
      flight_q <= flight_d;
    end
  end

  assign bus.turn       = turn_q;
  assign bus.throw_flag = flag_q;
  assign bus.speed      = speed_q;
  assign bus.game_over  = go_q;
  assign bus.winner     = win_q;

endmodule

// File: tb/tb_turn_manager.sv
// ---------------------------------------------------------------------------
// tb_turn_manager
// Self-checking bench for turn_manager with CHARGE_TICK = 10 and
// FLIGHT_TIMEOUT = 100. A phase-level reference model tracks what the game
// should be doing and derives speed from total held cycles; every cycle the
// registered outputs are compared against it. Directed scenarios add literal
// expectations, then a randomized run exercises everything together.
// ---------------------------------------------------------------------------
module tb_turn_manager;

  localparam int CT   = 10;
  localparam int FT   = 100;
  localparam int SMIN = 2;
  localparam int SMAX = 20;

  logic clk60MHz = 1'b0;
  logic rst      = 1'b1;

  always #5 clk60MHz = ~clk60MHz;

  turn_manager_if bus ();

  turn_manager #(
    .CHARGE_TICK   (CT),
    .SPEED_MIN     (SMIN),
    .SPEED_MAX     (SMAX),
    .FLIGHT_TIMEOUT(FT)
  ) dut (
    .clk60MHz(clk60MHz),
    .rst     (rst),
    .bus     (bus)
  );

  int n_cmp   = 0;
  int n_bad   = 0;
  int n_flags = 0;
  bit chk_en  = 1'b0;

  // ---------------- reference model ----------------
  typedef enum int {WAIT_RELEASE, WAIT_PRESS, CHARGING, AIRBORNE, JUDGE,
                    HANDOVER, ENDED} phase_t;
  phase_t phase = WAIT_RELEASE;
  int     m_held, m_fly, m_speed;
  bit     m_turn, m_flag, m_go;
  bit [1:0] m_win;

  function automatic bit dead(input logic [6:0] hp);
    return (int'(hp) == 0) || (int'(hp) > 100);
  endfunction

  always @(posedge clk60MHz) begin
    m_flag = 1'b0;
    if (rst) begin
      phase   = WAIT_RELEASE;
      m_turn  = 1'b0;
      m_speed = SMIN;
      m_go    = 1'b0;
      m_win   = 2'b00;
      m_held  = 0;
      m_fly   = 0;
    end else begin
      case (phase)
        WAIT_RELEASE: if (!bus.throw_btn) phase = WAIT_PRESS;
        WAIT_PRESS: if (bus.throw_btn) begin
          phase   = CHARGING;
          m_held  = 0;
          m_speed = SMIN;
        end
        CHARGING: if (bus.throw_btn) begin
          m_held++;
          m_speed = SMIN + m_held / CT;
          if (m_speed > SMAX) m_speed = SMAX;
        end else begin
          phase  = AIRBORNE;
          m_flag = 1'b1;
          m_fly  = 0;
        end
        AIRBORNE: begin
          m_fly++;
          if (bus.end_throw || m_fly == FT) phase = JUDGE;
        end
        JUDGE: begin
          if (dead(bus.hp_player1)) begin
            phase = ENDED; m_go = 1'b1; m_win = 2'b10;
          end else if (dead(bus.hp_player2)) begin
            phase = ENDED; m_go = 1'b1; m_win = 2'b01;
          end else begin
            phase  = HANDOVER;
            m_turn = ~m_turn;
          end
        end
        HANDOVER: phase = WAIT_RELEASE;
        ENDED: ;
        default: phase = WAIT_RELEASE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk60MHz) begin
    logic [9:0] act, exp;
    n_flags += int'(bus.throw_flag);
    if (chk_en) begin
      act = {bus.turn, bus.throw_flag, bus.speed, bus.game_over, bus.winner};
      exp = {m_turn, m_flag, 5'(m_speed), m_go, m_win};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL cycle_model @%0t: {turn,flag,speed,go,winner} got %b_%b_%0d_%b_%b expected %b_%b_%0d_%b_%b",
                 $time, act[9], act[8], act[7:3], act[2], act[1:0],
                 exp[9], exp[8], exp[7:3], exp[2], exp[1:0]);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk60MHz);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_end();
    bus.end_throw = 1'b1;
    step(1);
    bus.end_throw = 1'b0;
  endtask

  function automatic logic [6:0] pick_hp();
    case ($urandom_range(0, 15))
      0: return 7'd0;
      1: return 7'd101;
      2: return 7'd127;
      3: return 7'd100;
      4: return 7'd1;
      default: return 7'($urandom_range(1, 100));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int flags0;
    bus.throw_btn  = 1'b1;
    bus.end_throw  = 1'b0;
    bus.hp_player1 = 7'd100;
    bus.hp_player2 = 7'd100;

    // Reset with the button held; held button must not start a throw.
    rst = 1'b1;
    step(3);
    chk_en = 1'b1;
    chk("reset_turn", int'(bus.turn), 0);
    chk("reset_flag", int'(bus.throw_flag), 0);
    chk("reset_speed", int'(bus.speed), 2);
    chk("reset_game_over", int'(bus.game_over), 0);
    chk("reset_winner", int'(bus.winner), 0);
    rst = 1'b0;
    flags0 = n_flags;
    step(50);
    chk("held_btn_no_flag", n_flags - flags0, 0);
    chk("held_btn_speed", int'(bus.speed), 2);

    // 35-cycle press then release.
    bus.throw_btn = 1'b0;
    step(2);
    bus.throw_btn = 1'b1;
    step(35);
    bus.throw_btn = 1'b0;
    flags0 = n_flags;
    step(1);
    chk("press35_flag", int'(bus.throw_flag), 1);
    chk("press35_speed", int'(bus.speed), 5);
    chk("press35_turn", int'(bus.turn), 0);
    step(1);
    chk("press35_flag_single", int'(bus.throw_flag), 0);
    chk("press35_flag_count", n_flags - flags0, 1);

    // end_throw with both alive -> turn toggles two cycles later.
    bus.hp_player1 = 7'd100;
    bus.hp_player2 = 7'd70;
    pulse_end();
    step(1);
    chk("alive_turn", int'(bus.turn), 1);
    step(1);
    chk("alive_game_over", int'(bus.game_over), 0);
    chk("alive_speed_held", int'(bus.speed), 5);

    // Flight timeout: exactly FT cycles in flight.
    step(1);
    bus.throw_btn = 1'b1;
    step(3);
    bus.throw_btn = 1'b0;
    step(1);
    chk("timeout_flag", int'(bus.throw_flag), 1);
    step(FT);
    chk("timeout_turn_before", int'(bus.turn), 1);
    step(1);
    chk("timeout_turn_after", int'(bus.turn), 0);
    step(1);

    // Saturation, then player 2 dead via wrap.
    step(1);
    bus.throw_btn = 1'b1;
    step(500);
    chk("saturate_speed", int'(bus.speed), 20);
    bus.throw_btn = 1'b0;
    step(1);
    bus.hp_player1 = 7'd50;
    bus.hp_player2 = 7'd120;
    pulse_end();
    step(1);
    chk("p2dead_game_over", int'(bus.game_over), 1);
    chk("p2dead_winner", int'(bus.winner), 1);
    flags0 = n_flags;
    repeat (5) begin
      bus.throw_btn = 1'b0;
      step(3);
      bus.throw_btn = 1'b1;
      step(20);
      pulse_end();
    end
    bus.throw_btn = 1'b0;
    step(3);
    chk("over_no_flag", n_flags - flags0, 0);
    chk("over_winner_held", int'(bus.winner), 1);
    chk("over_turn_held", int'(bus.turn), 0);

    // Reset out of OVER, then reset mid-flight.
    bus.hp_player1 = 7'd80;
    bus.hp_player2 = 7'd80;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    bus.throw_btn = 1'b1;
    step(15);
    bus.throw_btn = 1'b0;
    step(6);
    rst = 1'b1;
    step(1);
    chk("midflight_rst_outputs",
        int'({bus.turn, bus.throw_flag, bus.speed, bus.game_over, bus.winner}),
        int'({1'b0, 1'b0, 5'd2, 1'b0, 2'b00}));
    rst = 1'b0;

    // Both dead: player 1 takes priority -> winner 10.
    step(1);
    bus.throw_btn = 1'b1;
    step(2);
    bus.throw_btn = 1'b0;
    step(1);
    bus.hp_player1 = 7'd0;
    bus.hp_player2 = 7'd0;
    pulse_end();
    step(1);
    chk("bothdead_winner", int'(bus.winner), 2);
    rst = 1'b1;
    step(2);
    rst = 1'b0;

    // Randomized run against the model.
    for (int i = 0; i < 5000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 14) == 0) bus.throw_btn = ~bus.throw_btn;
      bus.end_throw = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.hp_player1 = pick_hp();
        bus.hp_player2 = pick_hp();
      end
      step(1);
    end
    rst = 1'b0;
    bus.end_throw = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
